// File: rtl/key_schedule_sequencer_pkg.sv
// Shared definitions for the AES-128 key-schedule sequencer: sizes, FSM encoding
// and the RCON byte table.
package key_schedule_sequencer_pkg;

    localparam int unsigned NR_128    = 10;
    localparam int unsigned KEY_L_128 = 128;
    localparam int unsigned WORD_32   = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // RCON byte for expansion rounds 1..10; anything else maps to zero.
    function automatic logic [7:0] rcon_byte(input int unsigned rnd);
        logic [7:0] rc;
        case (rnd)
            1:       rc = 8'h01;
            2:       rc = 8'h02;
            3:       rc = 8'h04;
            4:       rc = 8'h08;
            5:       rc = 8'h10;
            6:       rc = 8'h20;
            7:       rc = 8'h40;
            8:       rc = 8'h80;
            9:       rc = 8'h1b;
            10:      rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/key_schedule_sequencer_if.sv
// Key intake, generation-stage and round-key read signals of the sequencer.
// slave = sequencer side, master = surrounding pipeline side.
interface key_schedule_sequencer_if
    import key_schedule_sequencer_pkg::*;
#(
    parameter int unsigned KEY_L = KEY_L_128,
    parameter int unsigned WORD  = WORD_32,
    parameter int unsigned AW    = 4
);

    logic [KEY_L-1:0] key_in;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_L-1:0] gen_key;
    logic [WORD-1:0]  gen_rcon;
    logic             gen_valid;
    logic [KEY_L-1:0] gen_round_key;
    logic             gen_valid_out;
    logic [AW-1:0]    rd_addr;
    logic [KEY_L-1:0] rd_data;
    logic             keys_valid;
    logic             busy;

    modport slave (
        input  key_in, key_valid, gen_round_key, gen_valid_out, rd_addr,
        output key_ready, gen_key, gen_rcon, gen_valid, rd_data, keys_valid, busy
    );

    modport master (
        output key_in, key_valid, gen_round_key, gen_valid_out, rd_addr,
        input  key_ready, gen_key, gen_rcon, gen_valid, rd_data, keys_valid, busy
    );

endinterface

// File: rtl/key_schedule_sequencer_round_key_store.sv
// (NR+1)-entry round-key register file: one write port, one registered read port.
// Addresses beyond NR read as zero and are never written.
module key_schedule_sequencer_round_key_store
    import key_schedule_sequencer_pkg::*;
#(
    parameter int unsigned KEY_L = KEY_L_128,
    parameter int unsigned NR    = NR_128,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [KEY_L-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [KEY_L-1:0] o_rd_data
);

    logic [KEY_L-1:0] r_mem [NR+1];
    logic [KEY_L-1:0] r_rd_data;
    logic             w_wr_in_range;
    logic             w_rd_in_range;

    assign w_wr_in_range = (i_wr_addr <= AW'(NR));
    assign w_rd_in_range = (i_rd_addr <= AW'(NR));

    // Read and write share the edge, so a same-cycle read sees the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_wr_en && w_wr_in_range) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            if (w_rd_in_range) begin
                r_rd_data <= r_mem[i_rd_addr];
            end else begin
                r_rd_data <= '0;
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/key_schedule_sequencer.sv
// AES-128 key-expansion controller: drives the single-round generation stage NR
// times with the right RCON, feeding each round key back, and stores all NR+1 keys.
module key_schedule_sequencer
    import key_schedule_sequencer_pkg::*;
#(
    parameter int unsigned KEY_L = KEY_L_128,
    parameter int unsigned WORD  = WORD_32,
    parameter int unsigned NR    = NR_128,
    parameter int unsigned AW    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    key_schedule_sequencer_if.slave  bus
);

    state_t           r_state;
    logic [AW-1:0]    r_rnd;
    logic [KEY_L-1:0] r_gen_key;
    logic [WORD-1:0]  r_gen_rcon;
    logic             r_gen_valid;
    logic             r_key_ready;
    logic             r_keys_valid;
    logic             r_busy;

    logic             w_accept;
    logic             w_store_round;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [KEY_L-1:0] w_wr_data;
    logic [KEY_L-1:0] w_rd_data;

    function automatic logic [WORD-1:0] rcon_word(input int unsigned rnd);
        return {rcon_byte(rnd), {(WORD-8){1'b0}}};
    endfunction

    assign w_accept      = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.key_valid;
    assign w_store_round = (r_state == S_WAIT) && bus.gen_valid_out;

    // Entry 0 takes the cipher key on acceptance; entries 1..NR take returned round keys.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (w_accept) begin
            w_wr_en   = 1'b1;
            w_wr_data = bus.key_in;
        end else if (w_store_round) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_rnd;
            w_wr_data = bus.gen_round_key;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_rnd        <= '0;
            r_gen_key    <= '0;
            r_gen_rcon   <= '0;
            r_gen_valid  <= 1'b0;
            r_key_ready  <= 1'b1;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.key_valid) begin
                        r_gen_key    <= bus.key_in;
                        r_rnd        <= AW'(1);
                        r_gen_rcon   <= rcon_word(1);
                        r_gen_valid  <= 1'b1;
                        r_key_ready  <= 1'b0;
                        r_keys_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_gen_valid <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.gen_valid_out) begin
                        r_gen_key <= bus.gen_round_key;
                        if (r_rnd == AW'(NR)) begin
                            r_keys_valid <= 1'b1;
                            r_busy       <= 1'b0;
                            r_key_ready  <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            // RCON is loaded for the round about to be issued.
                            r_rnd       <= r_rnd + AW'(1);
                            r_gen_rcon  <= rcon_word(32'(r_rnd) + 32'd1);
                            r_gen_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    key_schedule_sequencer_round_key_store #(
        .KEY_L (KEY_L),
        .NR    (NR),
        .AW    (AW)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (bus.rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign bus.key_ready  = r_key_ready;
    assign bus.gen_key    = r_gen_key;
    assign bus.gen_rcon   = r_gen_rcon;
    assign bus.gen_valid  = r_gen_valid;
    assign bus.keys_valid = r_keys_valid;
    assign bus.busy       = r_busy;
    assign bus.rd_data    = w_rd_data;

    a_rnd_bounded: assert property (@(posedge clk) disable iff (!reset) r_rnd <= AW'(NR));
    a_ready_idle:  assert property (@(posedge clk) disable iff (!reset) !(r_key_ready && r_busy));

endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Directed bench for key_schedule_sequencer with a behavioural generation stage
// of programmable latency that returns the FIPS-197 schedule for its known key.
module tb_key_schedule_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_schedule_sequencer_if #(.KEY_L(128), .WORD(32), .AW(4)) bus ();

    key_schedule_sequencer #(.KEY_L(128), .WORD(32), .NR(10), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] fips   [0:10];
    logic [7:0]   rc_exp [1:10];
    logic [127:0] k2 = 128'h000102030405060708090a0b0c0d0e0f;

    // Generation-stage model: known FIPS keys map to the next FIPS round key,
    // any other key to rotl8(key) ^ {4{rcon}}.
    int           m_lat = 3;
    int           m_cnt;
    logic [127:0] m_res;
    logic         stray = 1'b0;
    logic [31:0]  rcon_log [0:127];
    int           rcon_total = 0;
    int           rc_base = 0;

    function automatic logic [127:0] gen_f(input logic [127:0] k, input logic [31:0] rc);
        for (int i = 0; i < 10; i++) begin
            if (k == fips[i]) return fips[i+1];
        end
        return {k[119:0], k[127:120]} ^ {4{rc}};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= 0;
            m_res <= '0;
        end else if (bus.gen_valid) begin
            m_cnt <= m_lat;
            m_res <= gen_f(bus.gen_key, bus.gen_rcon);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (reset && bus.gen_valid && rcon_total < 128) begin
            rcon_log[rcon_total] <= bus.gen_rcon;
            rcon_total           <= rcon_total + 1;
        end
    end

    assign bus.gen_valid_out = (m_cnt == 1) || stray;
    assign bus.gen_round_key = m_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after acceptance until keys_valid; n is -100 on timeout.
    task automatic wait_kv(output int n, output bit rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            n++;
            if (bus.keys_valid) return;
            if (bus.key_ready) rdy_seen = 1'b1;
        end
        n = -100;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %0b want 1", bus.key_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid got %0b want 0", bus.keys_valid); end
        checks++; if (bus.gen_valid !== 1'b0) begin errors++; $display("FAIL reset_gen_valid got %0b want 0", bus.gen_valid); end
        checks++; if (bus.gen_key !== 128'h0) begin errors++; $display("FAIL reset_gen_key got %h want 0", bus.gen_key); end
        checks++; if (bus.gen_rcon !== 32'h0) begin errors++; $display("FAIL reset_gen_rcon got %h want 0", bus.gen_rcon); end
        checks++; if (bus.rd_data !== 128'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fips();
        int n;
        bit rdy;
        rc_base = rcon_total;
        bus.key_in    = fips[0];
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        wait_kv(n, rdy);
        checks++; if (n + 1 != 41) begin errors++; $display("FAIL fips_latency got %0d want 41", n + 1); end
        checks++; if (bus.busy !== 1'b0 || bus.key_ready !== 1'b1) begin errors++; $display("FAIL fips_done_flags got busy=%0b ready=%0b want 0/1", bus.busy, bus.key_ready); end
        for (int a = 0; a <= 10; a++) begin
            bus.rd_addr = 4'(a);
            tick();
            checks++; if (bus.rd_data !== fips[a]) begin errors++; $display("FAIL fips_rd_%0d got %h want %h", a, bus.rd_data, fips[a]); end
        end
    endtask

    task automatic test_rcon();
        checks++; if (rcon_total - rc_base != 10) begin errors++; $display("FAIL rcon_count got %0d want 10", rcon_total - rc_base); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rcon_log[rc_base+i] !== {rc_exp[i+1], 24'h0}) begin
                errors++; $display("FAIL rcon_%0d got %h want %h", i + 1, rcon_log[rc_base+i], {rc_exp[i+1], 24'h0});
            end
        end
    endtask

    task automatic test_hold_key();
        int n;
        bit rdy;
        logic [127:0] e;
        bus.key_in    = fips[0];
        bus.key_valid = 1'b1;
        tick();
        checks++; if (bus.keys_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL hold_restart got kv=%0b busy=%0b want 0/1", bus.keys_valid, bus.busy); end
        bus.key_in = k2;
        wait_kv(n, rdy);
        checks++; if (n + 1 != 41) begin errors++; $display("FAIL hold_latency got %0d want 41", n + 1); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL hold_ready_low got %0b want 0", rdy); end
        bus.rd_addr = 4'd0;
        tick();
        checks++; if (bus.rd_data !== fips[0]) begin errors++; $display("FAIL hold_same_cycle_read got %h want %h", bus.rd_data, fips[0]); end
        checks++; if (bus.keys_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL hold_second_accept got kv=%0b busy=%0b want 0/1", bus.keys_valid, bus.busy); end
        bus.key_valid = 1'b0;
        bus.rd_addr   = 4'd10;
        tick();
        checks++; if (bus.rd_data !== fips[10]) begin errors++; $display("FAIL hold_old_rd10 got %h want %h", bus.rd_data, fips[10]); end
        bus.rd_addr = 4'd5;
        tick();
        checks++; if (bus.rd_data !== fips[5]) begin errors++; $display("FAIL hold_old_rd5 got %h want %h", bus.rd_data, fips[5]); end
        bus.rd_addr = 4'd0;
        tick();
        checks++; if (bus.rd_data !== k2) begin errors++; $display("FAIL hold_new_rd0 got %h want %h", bus.rd_data, k2); end
        wait_kv(n, rdy);
        checks++; if (n <= 0) begin errors++; $display("FAIL hold_second_done got %0d want >0", n); end
        e = k2;
        for (int r = 1; r <= 10; r++) begin
            e = gen_f(e, {rc_exp[r], 24'h0});
            bus.rd_addr = 4'(r);
            tick();
            checks++; if (bus.rd_data !== e) begin errors++; $display("FAIL hold_k2_rd_%0d got %h want %h", r, bus.rd_data, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        bus.key_in    = fips[0];
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.gen_valid && bus.gen_rcon == 32'h10000000) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL midreset_round5 got none want gen_valid rcon 10000000"); end
        reset = 1'b0;
        #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL midreset_keys_valid got %0b want 0", bus.keys_valid); end
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL midreset_key_ready got %0b want 1", bus.key_ready); end
        checks++; if (bus.gen_valid !== 1'b0) begin errors++; $display("FAIL midreset_gen_valid got %0b want 0", bus.gen_valid); end
        tick();
        reset = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            tick();
            checks++; if (bus.rd_data !== 128'h0) begin errors++; $display("FAIL midreset_rd_%0d got %h want 0", a, bus.rd_data); end
        end
    endtask

    task automatic test_stray_lat1();
        int n;
        bit rdy;
        m_lat = 1;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        checks++; if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || bus.keys_valid !== 1'b0) begin
            errors++; $display("FAIL stray_idle_flags got ready=%0b busy=%0b kv=%0b want 1/0/0", bus.key_ready, bus.busy, bus.keys_valid);
        end
        bus.rd_addr = 4'd1;
        tick();
        checks++; if (bus.rd_data !== 128'h0) begin errors++; $display("FAIL stray_idle_rd1 got %h want 0", bus.rd_data); end
        bus.key_in    = fips[0];
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        wait_kv(n, rdy);
        checks++; if (n + 1 != 21) begin errors++; $display("FAIL lat1_latency got %0d want 21", n + 1); end
        bus.rd_addr = 4'd10;
        tick();
        checks++; if (bus.rd_data !== fips[10]) begin errors++; $display("FAIL lat1_rd10 got %h want %h", bus.rd_data, fips[10]); end
    endtask

    task automatic test_read_bounds();
        bus.rd_addr = 4'd11;
        tick();
        checks++; if (bus.rd_data !== 128'h0) begin errors++; $display("FAIL oob_rd11 got %h want 0", bus.rd_data); end
        bus.rd_addr = 4'd15;
        tick();
        checks++; if (bus.rd_data !== 128'h0) begin errors++; $display("FAIL oob_rd15 got %h want 0", bus.rd_data); end
        bus.rd_addr = 4'd0;
        #2;
        checks++; if (bus.rd_data !== 128'h0) begin errors++; $display("FAIL rd0_before_edge got %h want 0", bus.rd_data); end
        tick();
        checks++; if (bus.rd_data !== fips[0]) begin errors++; $display("FAIL rd0_after_edge got %h want %h", bus.rd_data, fips[0]); end
    endtask

    task automatic test_stray_done();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        checks++; if (bus.keys_valid !== 1'b1 || bus.busy !== 1'b0 || bus.gen_valid !== 1'b0) begin
            errors++; $display("FAIL stray_done_flags got kv=%0b busy=%0b gv=%0b want 1/0/0", bus.keys_valid, bus.busy, bus.gen_valid);
        end
        bus.rd_addr = 4'd10;
        tick();
        checks++; if (bus.rd_data !== fips[10]) begin errors++; $display("FAIL stray_done_rd10 got %h want %h", bus.rd_data, fips[10]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        rc_exp[1] = 8'h01; rc_exp[2] = 8'h02; rc_exp[3] = 8'h04; rc_exp[4]  = 8'h08;
        rc_exp[5] = 8'h10; rc_exp[6] = 8'h20; rc_exp[7] = 8'h40; rc_exp[8]  = 8'h80;
        rc_exp[9] = 8'h1b; rc_exp[10] = 8'h36;
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rd_addr   = '0;

        test_reset();
        test_fips();
        test_rcon();
        test_hold_key();
        test_reset_mid();
        test_stray_lat1();
        test_read_bounds();
        test_stray_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
